// File: rtl/note_scroller_pkg.sv
// Shared definitions for the note scroller: FSM state encoding and the
// colour constants used by the note lanes (red don, blue ka, black erase).
package note_scroller_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    WAIT  = 3'd2,
    ERASE = 3'd3,
    MOVE  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] BLACK = 3'b000;

endpackage

// File: rtl/note_scroller_sprite_scan_counter.sv
// Pixel scan counter for a SIZE x SIZE sprite.
// px is the inner (fast) index, py the outer index, both 0..SIZE-1.
// Ports:
//   clock, reset  : clock and asynchronous active-high reset
//   clear         : synchronous return to pixel (0,0)
//   enable        : advance one pixel
//   px, py        : current pixel offsets within the sprite
//   last          : current pixel is (SIZE-1, SIZE-1)
// SIZE is a power of two, so both counters wrap to 0 on their own after
// the last pixel.
module sprite_scan_counter #(
  parameter int SIZE = 4,
  parameter int CW   = $clog2(SIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic          last
);

  localparam logic [CW-1:0] MAX = CW'(SIZE - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px <= '0;
      py <= '0;
    end else if (clear) begin
      px <= '0;
      py <= '0;
    end else if (enable) begin
      px <= px + 1'b1;
      if (px == MAX) py <= py + 1'b1;
    end
  end

  assign last = (px == MAX) && (py == MAX);

endmodule

// File: rtl/note_scroller.sv
// Note scroller: animates one SIZE x SIZE note sprite right-to-left toward
// the hit line, emitting pixel-plot writes for the VGA adapter.
// Each frame tick erases the sprite, steps x left by STEP and redraws it.
// Ports:
//   clock, reset      : clock and asynchronous active-high reset
//   go                : start a note (IDLE only); latches start_x/start_y/colour_in
//   frame_tick        : one-cycle pulse per frame (honoured only in WAIT)
//   busy              : note in flight
//   plot, out_x/out_y/out_colour : registered pixel write
//   cur_x             : current left-edge x
//   finished          : one-cycle pulse when the note leaves the lane
// Optional feature macro NOTE_SCROLLER_HIT_EN adds input hit and output
// hit_ok: a hit in WAIT erases the note and finishes it where it stands.
module note_scroller
  import note_scroller_pkg::*;
#(
  parameter int         X_W       = 8,
  parameter int         Y_W       = 7,
  parameter int         SIZE      = 4,
  parameter int         STEP      = 4,
  parameter int         END_X     = 0,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           go,
  input  logic           frame_tick,
  input  logic [X_W-1:0] start_x,
  input  logic [Y_W-1:0] start_y,
  input  logic [2:0]     colour_in,
`ifdef NOTE_SCROLLER_HIT_EN
  input  logic           hit,
  output logic           hit_ok,
`endif
  output logic           busy,
  output logic           plot,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y,
  output logic [2:0]     out_colour,
  output logic [X_W-1:0] cur_x,
  output logic           finished
);

  localparam int CW = $clog2(SIZE);
  // One extra bit so END_X+STEP never wraps in the finish test.
  localparam logic [X_W:0] LIMIT = (X_W+1)'(END_X + STEP);

  state_t         state, next_state;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     col;
  logic           load, step_x, scanning, hit_pend;
  logic [CW-1:0]  px, py;
  logic           last;

  assign scanning = (state == DRAW) || (state == ERASE);
  assign cur_x    = x;

  sprite_scan_counter #(.SIZE(SIZE), .CW(CW)) u_scan (
    .clock  (clock),
    .reset  (reset),
    .clear  (!scanning),
    .enable (scanning),
    .px     (px),
    .py     (py),
    .last   (last)
  );

`ifdef NOTE_SCROLLER_HIT_EN
  localparam logic [X_W:0] HIT_LIMIT = (X_W+1)'(END_X + 2*STEP);
  logic set_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_pend <= 1'b0;
      hit_ok   <= 1'b0;
    end else begin
      if (set_hit)            hit_pend <= 1'b1;
      else if (state == DONE) hit_pend <= 1'b0;
      hit_ok <= (next_state == DONE) && hit_pend && ({1'b0, x} <= HIT_LIMIT);
    end
  end
`else
  assign hit_pend = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step_x     = 1'b0;
`ifdef NOTE_SCROLLER_HIT_EN
    set_hit    = 1'b0;
`endif
    case (state)
      IDLE: if (go) begin
        load       = 1'b1;
        next_state = DRAW;
      end
      DRAW: if (last) next_state = WAIT;
      WAIT: begin
`ifdef NOTE_SCROLLER_HIT_EN
        if (hit) begin
          set_hit    = 1'b1;
          next_state = ERASE;
        end else
`endif
        if (frame_tick) next_state = ERASE;
      end
      ERASE: if (last) next_state = MOVE;
      MOVE: begin
        if (hit_pend || ({1'b0, x} < LIMIT)) begin
          next_state = DONE;
        end else begin
          step_x     = 1'b1;
          next_state = DRAW;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pixel outputs are registered from the scan position, so each plot
  // appears one cycle after its DRAW/ERASE cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      col        <= '0;
      plot       <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_colour <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
    end else begin
      if (load) begin
        x   <= start_x;
        y   <= start_y;
        col <= colour_in;
      end else if (step_x) begin
        x <= x - X_W'(STEP);
      end
      plot <= scanning;
      if (scanning) begin
        out_x      <= x + X_W'(px);
        out_y      <= y + Y_W'(py);
        out_colour <= (state == ERASE) ? BG_COLOUR : col;
      end
      busy     <= (next_state != IDLE) && (next_state != DONE);
      finished <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_note_scroller.sv
// Directed self-checking bench for note_scroller (default parameters).
// Hit-feature scenarios run only when NOTE_SCROLLER_HIT_EN is defined.
module tb_note_scroller;

  logic       clock = 1'b0;
  logic       reset, go, frame_tick;
  logic [7:0] start_x;
  logic [6:0] start_y;
  logic [2:0] colour_in;
  logic       busy, plot, finished;
  logic [7:0] out_x, cur_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
`ifdef NOTE_SCROLLER_HIT_EN
  logic       hit, hit_ok, fin_hit;
`endif

  int checks = 0;
  int passed = 0;

  logic [7:0] lx[$];
  logic [6:0] ly[$];
  logic [2:0] lc[$];
  int         fin_cnt;
  logic [7:0] fin_x;
  logic       fin_busy;

  note_scroller dut (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .frame_tick (frame_tick),
    .start_x    (start_x),
    .start_y    (start_y),
    .colour_in  (colour_in),
`ifdef NOTE_SCROLLER_HIT_EN
    .hit        (hit),
    .hit_ok     (hit_ok),
`endif
    .busy       (busy),
    .plot       (plot),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_colour (out_colour),
    .cur_x      (cur_x),
    .finished   (finished)
  );

  always #5 clock = ~clock;

  // Pixel/finish logger, sampled 1 time unit after each rising edge.
  always @(posedge clock) begin
    #1;
    if (plot) begin
      lx.push_back(out_x);
      ly.push_back(out_y);
      lc.push_back(out_colour);
    end
    if (finished) begin
      fin_cnt++;
      fin_x    = cur_x;
      fin_busy = busy;
`ifdef NOTE_SCROLLER_HIT_EN
      fin_hit  = hit_ok;
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_log();
    lx.delete(); ly.delete(); lc.delete();
    fin_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic start_note(input logic [7:0] sx, input logic [6:0] sy, input logic [2:0] c);
    start_x = sx; start_y = sy; colour_in = c;
    go = 1'b1;
    step(1);
    go = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; frame_tick = 1'b0;
    start_x = '0; start_y = '0; colour_in = '0;
`ifdef NOTE_SCROLLER_HIT_EN
    hit = 1'b0;
`endif
    step(2);
    checks++; if (plot !== 1'b0) $display("FAIL reset_plot got %b want 0", plot); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (finished !== 1'b0) $display("FAIL reset_finished got %b want 0", finished); else passed++;
    checks++; if (cur_x !== 8'd0) $display("FAIL reset_cur_x got %0d want 0", cur_x); else passed++;
    checks++; if (out_x !== 8'd0) $display("FAIL reset_out_x got %0d want 0", out_x); else passed++;
    checks++; if (out_y !== 7'd0) $display("FAIL reset_out_y got %0d want 0", out_y); else passed++;
    checks++; if (out_colour !== 3'd0) $display("FAIL reset_out_colour got %b want 000", out_colour); else passed++;
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_draw();
    clear_log();
    start_note(8'd12, 7'd20, 3'b100);
    checks++; if (busy !== 1'b1) $display("FAIL draw_busy_after_go got %b want 1", busy); else passed++;
    step(20);
    checks++; if (lx.size() !== 16) $display("FAIL draw_count got %0d want 16", lx.size()); else passed++;
    for (int i = 0; i < lx.size() && i < 16; i++) begin
      checks++;
      if (lx[i] !== 8'(12 + i % 4) || ly[i] !== 7'(20 + i / 4) || lc[i] !== 3'b100)
        $display("FAIL draw_pixel_%0d got (%0d,%0d,%b) want (%0d,%0d,100)",
                 i, lx[i], ly[i], lc[i], 12 + i % 4, 20 + i / 4);
      else passed++;
    end
    checks++; if (plot !== 1'b0) $display("FAIL draw_idle_plot got %b want 0", plot); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL draw_wait_busy got %b want 1", busy); else passed++;
  endtask

  task automatic test_ticks();
    int erases = 0;
    int draws  = 0;
    for (int k = 0; k < 4; k++) begin
      int xo  = 12 - 4 * k;
      int exp_n = (k < 3) ? 32 : 16;
      clear_log();
      pulse_tick();
      step(40);
      checks++;
      if (lx.size() !== exp_n) $display("FAIL tick%0d_count got %0d want %0d", k, lx.size(), exp_n);
      else passed++;
      for (int i = 0; i < lx.size() && i < exp_n; i++) begin
        int ex = (i < 16) ? xo + i % 4 : xo - 4 + i % 4;
        int ey = 20 + (i % 16) / 4;
        logic [2:0] ec = (i < 16) ? 3'b000 : 3'b100;
        if (lc[i] === 3'b000) erases++; else draws++;
        checks++;
        if (lx[i] !== 8'(ex) || ly[i] !== 7'(ey) || lc[i] !== ec)
          $display("FAIL tick%0d_pixel_%0d got (%0d,%0d,%b) want (%0d,%0d,%b)",
                   k, i, lx[i], ly[i], lc[i], ex, ey, ec);
        else passed++;
      end
      if (k < 3) begin
        checks++; if (cur_x !== 8'(xo - 4)) $display("FAIL tick%0d_cur_x got %0d want %0d", k, cur_x, xo - 4); else passed++;
        checks++; if (fin_cnt !== 0) $display("FAIL tick%0d_early_finish got %0d want 0", k, fin_cnt); else passed++;
      end
    end
    checks++; if (fin_cnt !== 1) $display("FAIL ticks_finish_cycles got %0d want 1", fin_cnt); else passed++;
    checks++; if (fin_x !== 8'd0) $display("FAIL ticks_finish_cur_x got %0d want 0", fin_x); else passed++;
    checks++; if (fin_busy !== 1'b0) $display("FAIL ticks_finish_busy got %b want 0", fin_busy); else passed++;
    checks++; if (erases !== 64) $display("FAIL ticks_erase_pixels got %0d want 64", erases); else passed++;
    checks++; if (draws !== 48) $display("FAIL ticks_draw_pixels got %0d want 48", draws); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL ticks_busy_after got %b want 0", busy); else passed++;
  endtask

  task automatic test_dropped();
    start_note(8'd40, 7'd10, 3'b001);
    step(3);
    pulse_tick();
    step(20);
    clear_log();
    start_note(8'd100, 7'd50, 3'b100);
    step(40);
    checks++; if (lx.size() !== 0) $display("FAIL dropped_plots got %0d want 0", lx.size()); else passed++;
    checks++; if (cur_x !== 8'd40) $display("FAIL dropped_cur_x got %0d want 40", cur_x); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL dropped_busy got %b want 1", busy); else passed++;
    clear_log();
    pulse_tick();
    step(40);
    checks++; if (lx.size() !== 32) $display("FAIL dropped_move_count got %0d want 32", lx.size()); else passed++;
    if (lx.size() == 32) begin
      checks++;
      if (lx[0] !== 8'd40 || lc[0] !== 3'b000) $display("FAIL dropped_erase got (%0d,%b) want (40,000)", lx[0], lc[0]);
      else passed++;
      checks++;
      if (lx[16] !== 8'd36 || ly[16] !== 7'd10 || lc[16] !== 3'b001)
        $display("FAIL dropped_redraw got (%0d,%0d,%b) want (36,10,001)", lx[16], ly[16], lc[16]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_erase();
    clear_log();
    pulse_tick();
    step(7);
    checks++; if (lx.size() !== 7) $display("FAIL mid_erase_progress got %0d want 7", lx.size()); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (plot !== 1'b0) $display("FAIL mid_reset_plot got %b want 0", plot); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got %b want 0", busy); else passed++;
    checks++; if (cur_x !== 8'd0) $display("FAIL mid_reset_cur_x got %0d want 0", cur_x); else passed++;
    step(1);
    reset = 1'b0;
    step(1);
    clear_log();
    start_note(8'd60, 7'd30, 3'b100);
    step(20);
    checks++; if (lx.size() !== 16) $display("FAIL restart_count got %0d want 16", lx.size()); else passed++;
    if (lx.size() == 16) begin
      checks++;
      if (lx[0] !== 8'd60 || ly[0] !== 7'd30 || lx[15] !== 8'd63 || ly[15] !== 7'd33)
        $display("FAIL restart_pixels got (%0d,%0d)..(%0d,%0d) want (60,30)..(63,33)", lx[0], ly[0], lx[15], ly[15]);
      else passed++;
    end
    checks++; if (cur_x !== 8'd60) $display("FAIL restart_cur_x got %0d want 60", cur_x); else passed++;
  endtask

  task automatic test_short();
    do_reset();
    clear_log();
    start_note(8'd3, 7'd5, 3'b100);
    step(20);
    checks++; if (lx.size() !== 16) $display("FAIL short_draw_count got %0d want 16", lx.size()); else passed++;
    if (lx.size() == 16) begin
      checks++;
      if (lx[0] !== 8'd3 || lx[15] !== 8'd6) $display("FAIL short_draw_x got %0d..%0d want 3..6", lx[0], lx[15]);
      else passed++;
    end
    clear_log();
    pulse_tick();
    step(40);
    checks++; if (lx.size() !== 16) $display("FAIL short_erase_count got %0d want 16", lx.size()); else passed++;
    if (lx.size() == 16) begin
      checks++;
      if (lx[15] !== 8'd6 || lc[15] !== 3'b000) $display("FAIL short_erase_last got (%0d,%b) want (6,000)", lx[15], lc[15]);
      else passed++;
    end
    checks++; if (fin_cnt !== 1) $display("FAIL short_finish got %0d want 1", fin_cnt); else passed++;
    checks++; if (fin_x !== 8'd3) $display("FAIL short_finish_cur_x got %0d want 3", fin_x); else passed++;
  endtask

`ifdef NOTE_SCROLLER_HIT_EN
  task automatic test_hit();
    do_reset();
    start_note(8'd12, 7'd20, 3'b100);
    step(20);
    pulse_tick();
    step(40);
    checks++; if (cur_x !== 8'd8) $display("FAIL hit_setup_cur_x got %0d want 8", cur_x); else passed++;
    clear_log();
    hit = 1'b1; step(1); hit = 1'b0;
    step(40);
    checks++; if (lx.size() !== 16) $display("FAIL hit_erase_count got %0d want 16", lx.size()); else passed++;
    checks++; if (fin_cnt !== 1) $display("FAIL hit_finish got %0d want 1", fin_cnt); else passed++;
    checks++; if (fin_x !== 8'd8) $display("FAIL hit_finish_cur_x got %0d want 8", fin_x); else passed++;
    checks++; if (fin_hit !== 1'b1) $display("FAIL hit_ok_near got %b want 1", fin_hit); else passed++;
    start_note(8'd12, 7'd20, 3'b001);
    step(20);
    clear_log();
    hit = 1'b1; frame_tick = 1'b1; step(1); hit = 1'b0; frame_tick = 1'b0;
    step(40);
    checks++; if (fin_cnt !== 1) $display("FAIL hit_far_finish got %0d want 1", fin_cnt); else passed++;
    checks++; if (fin_x !== 8'd12) $display("FAIL hit_far_cur_x got %0d want 12", fin_x); else passed++;
    checks++; if (fin_hit !== 1'b0) $display("FAIL hit_ok_far got %b want 0", fin_hit); else passed++;
  endtask
`endif

  initial begin
    fin_cnt = 0;
    test_reset();
    test_draw();
    test_ticks();
    test_dropped();
    test_reset_mid_erase();
    test_short();
`ifdef NOTE_SCROLLER_HIT_EN
    test_hit();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
